// File: rtl/csr_controller_ext.sv
// Machine-mode CSR controller: mstatus stacking, mip/mhartid, optional 64-bit counters,
// vectored trap target and illegal-access detection.
module csr_controller_ext #(
    parameter bit          HAS_COUNTERS   = 1'b1,
    parameter bit          MTVEC_VECTORED = 1'b1,
    parameter logic [31:0] RESET_MTVEC    = 32'h0000_0000,
    parameter logic [31:0] HART_ID        = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [2:0]  opcode_i,
    input  logic [11:0] addr_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] imm_data_i,
    input  logic        write_enable_i,
    input  logic        trap_i,
    input  logic        mret_i,
    input  logic        instret_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] mcause_i,
    input  logic [31:0] irq_i,
    output logic [31:0] read_data_o,
    output logic [31:0] mie_o,
    output logic [31:0] mepc_o,
    output logic [31:0] mtvec_o,
    output logic [31:0] trap_pc_o,
    output logic        mstatus_mie_o,
    output logic        irq_o,
    output logic        illegal_o
);

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

    localparam logic [31:0] MTVEC_RST = RESET_MTVEC & ~32'd3;

    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mip_q, mip_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;

    logic [31:0] rdata;
    logic        addr_ok;
    logic        addr_ro;
    logic [1:0]  op_kind;
    logic        op_ok;
    logic [31:0] src;
    logic [31:0] wdata;
    logic        commit;
    logic [31:0] mtvec_base;
    logic [63:0] mcycle_inc;
    logic [63:0] minstret_inc;

    // Modes 2/3 are reserved and collapse to direct mode.
    function automatic logic [31:0] mtvec_legalize(input logic [31:0] v);
        logic [1:0] mode;
        mode = (MTVEC_VECTORED && (v[1:0] == 2'b01)) ? 2'b01 : 2'b00;
        return {v[31:2], mode};
    endfunction

    always_comb begin
        rdata   = 32'd0;
        addr_ok = 1'b1;
        addr_ro = 1'b0;
        case (addr_i)
            ADDR_MSTATUS:   rdata = {19'd0, 2'b11, 3'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
            ADDR_MIE:       rdata = mie_q;
            ADDR_MTVEC:     rdata = mtvec_q;
            ADDR_MSCRATCH:  rdata = mscratch_q;
            ADDR_MEPC:      rdata = mepc_q;
            ADDR_MCAUSE:    rdata = mcause_q;
            ADDR_MIP: begin
                rdata   = mip_q;
                addr_ro = 1'b1;
            end
            ADDR_MHARTID: begin
                rdata   = HART_ID;
                addr_ro = 1'b1;
            end
            ADDR_MCYCLE: begin
                rdata   = mcycle_q[31:0];
                addr_ok = HAS_COUNTERS;
            end
            ADDR_MCYCLEH: begin
                rdata   = mcycle_q[63:32];
                addr_ok = HAS_COUNTERS;
            end
            ADDR_MINSTRET: begin
                rdata   = minstret_q[31:0];
                addr_ok = HAS_COUNTERS;
            end
            ADDR_MINSTRETH: begin
                rdata   = minstret_q[63:32];
                addr_ok = HAS_COUNTERS;
            end
            default:        addr_ok = 1'b0;
        endcase
    end

    // opcode[2] selects the immediate; opcode[1:0] is 01=write, 10=set, 11=clear.
    always_comb begin
        op_kind = opcode_i[1:0];
        op_ok   = (op_kind != 2'b00);
        src     = opcode_i[2] ? imm_data_i : rs1_data_i;
        case (op_kind)
            2'b10:   wdata = rdata | src;
            2'b11:   wdata = rdata & ~src;
            default: wdata = src;
        endcase
        illegal_o = write_enable_i & (~addr_ok | ~op_ok | (addr_ro & (op_kind == 2'b01)));
        commit    = write_enable_i & ~trap_i & ~mret_i & ~illegal_o;
    end

    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mip_d          = irq_i;
        mcycle_inc     = mcycle_q + 64'd1;
        minstret_inc   = minstret_q + {63'd0, instret_i};
        mcycle_d       = HAS_COUNTERS ? mcycle_inc : 64'd0;
        minstret_d     = HAS_COUNTERS ? minstret_inc : 64'd0;

        if (trap_i) begin
            mepc_d         = {pc_i[31:2], 2'b00};
            mcause_d       = mcause_i;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret_i) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (commit) begin
            // A counter write replaces that cycle's increment for the whole 64-bit counter.
            case (addr_i)
                ADDR_MSTATUS: begin
                    mstatus_mie_d  = wdata[3];
                    mstatus_mpie_d = wdata[7];
                end
                ADDR_MIE:       mie_d      = wdata;
                ADDR_MTVEC:     mtvec_d    = mtvec_legalize(wdata);
                ADDR_MSCRATCH:  mscratch_d = wdata;
                ADDR_MEPC:      mepc_d     = {wdata[31:2], 2'b00};
                ADDR_MCAUSE:    mcause_d   = wdata;
                ADDR_MCYCLE:    mcycle_d   = {mcycle_q[63:32], wdata};
                ADDR_MCYCLEH:   mcycle_d   = {wdata, mcycle_q[31:0]};
                ADDR_MINSTRET:  minstret_d = {minstret_q[63:32], wdata};
                ADDR_MINSTRETH: minstret_d = {wdata, minstret_q[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= 32'd0;
            mtvec_q        <= MTVEC_RST;
            mscratch_q     <= 32'd0;
            mepc_q         <= 32'd0;
            mcause_q       <= 32'd0;
            mip_q          <= 32'd0;
            mcycle_q       <= 64'd0;
            minstret_q     <= 64'd0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mip_q          <= mip_d;
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
        end
    end

    always_comb begin
        mtvec_base = {mtvec_q[31:2], 2'b00};
        if ((mtvec_q[1:0] == 2'b01) && mcause_i[31]) begin
            trap_pc_o = mtvec_base + {mcause_i[29:0], 2'b00};
        end else begin
            trap_pc_o = mtvec_base;
        end
    end

    assign read_data_o   = rdata;
    assign mie_o         = mie_q;
    assign mepc_o        = mepc_q;
    assign mtvec_o       = mtvec_q;
    assign mstatus_mie_o = mstatus_mie_q;
    assign irq_o         = mstatus_mie_q & (|(mip_q & mie_q));

endmodule

// File: tb/tb_csr_controller_ext.sv
// Directed self-checking bench for csr_controller_ext with hand-computed expectations.
module tb_csr_controller_ext;

    localparam logic [2:0] OP_RW  = 3'b001;
    localparam logic [2:0] OP_RS  = 3'b010;
    localparam logic [2:0] OP_RC  = 3'b011;
    localparam logic [2:0] OP_RWI = 3'b101;
    localparam logic [2:0] OP_RCI = 3'b111;
    localparam logic [2:0] OP_BAD = 3'b100;

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    logic        clk, rst_n;
    logic [2:0]  opcode;
    logic [11:0] addr;
    logic [31:0] rs1_data, imm_data, pc, mcause, irq;
    logic        we, trap, mret, instret;
    logic [31:0] read_data, mie, mepc, mtvec, trap_pc;
    logic        mstatus_mie, irq_out, illegal;

    int n_checks = 0;
    int n_errors = 0;

    csr_controller_ext #(
        .HAS_COUNTERS   (1'b1),
        .MTVEC_VECTORED (1'b1),
        .RESET_MTVEC    (32'h0000_1003),
        .HART_ID        (32'h0000_0005)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_n),
        .opcode_i       (opcode),
        .addr_i         (addr),
        .rs1_data_i     (rs1_data),
        .imm_data_i     (imm_data),
        .write_enable_i (we),
        .trap_i         (trap),
        .mret_i         (mret),
        .instret_i      (instret),
        .pc_i           (pc),
        .mcause_i       (mcause),
        .irq_i          (irq),
        .read_data_o    (read_data),
        .mie_o          (mie),
        .mepc_o         (mepc),
        .mtvec_o        (mtvec),
        .trap_pc_o      (trap_pc),
        .mstatus_mie_o  (mstatus_mie),
        .irq_o          (irq_out),
        .illegal_o      (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
        addr = a;
        we   = 1'b0;
        #1;
        check(tag, read_data, exp);
    endtask

    // Drives the unused operand with the complement so a wrong source select is visible.
    task automatic set_op(input logic [2:0] op, input logic [11:0] a, input logic [31:0] d);
        opcode = op;
        addr   = a;
        if (op[2]) begin
            imm_data = d;
            rs1_data = ~d;
        end else begin
            rs1_data = d;
            imm_data = ~d;
        end
        we = 1'b1;
    endtask

    task automatic wr(input logic [2:0] op, input logic [11:0] a, input logic [31:0] d);
        set_op(op, a, d);
        tick();
        we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; opcode = OP_RW; addr = A_MIE; rs1_data = 32'hFFFF_FFFF; imm_data = 32'd0;
        we = 1'b1; trap = 1'b1; mret = 1'b0; instret = 1'b0;
        pc = 32'h0000_0444; mcause = 32'h0000_0009; irq = 32'd0;
        tick();
        tick();
        rst_n = 1'b1; we = 1'b0; trap = 1'b0; pc = 32'd0; mcause = 32'd0;
        #1;
        check("rst_mie", mie, 32'd0);
        check("rst_mepc", mepc, 32'd0);
        check("rst_mtvec", mtvec, 32'h0000_1000);
        check("rst_mstatus_mie", {31'd0, mstatus_mie}, 32'd0);
        check("rst_irq", {31'd0, irq_out}, 32'd0);
        rd(A_MSTATUS, 32'h0000_1800, "rst_mstatus");
        rd(A_MCAUSE, 32'd0, "rst_mcause");
        rd(A_MHARTID, 32'h0000_0005, "mhartid");
        check("rst_trap_pc", trap_pc, 32'h0000_1000);

        // Vectored mtvec
        wr(OP_RW, A_MTVEC, 32'h8000_0101);
        check("mtvec_vec", mtvec, 32'h8000_0101);
        mcause = 32'h8000_0007; #1;
        check("trap_pc_vec", trap_pc, 32'h8000_011C);
        mcause = 32'h0000_0002; #1;
        check("trap_pc_exc", trap_pc, 32'h8000_0100);
        wr(OP_RW, A_MTVEC, 32'h8000_0103);
        check("mtvec_mode3", mtvec, 32'h8000_0100);
        mcause = 32'h8000_0007; #1;
        check("trap_pc_mode3", trap_pc, 32'h8000_0100);

        // mstatus stacking through trap and mret
        wr(OP_RWI, A_MSTATUS, 32'h0000_0008);
        rd(A_MSTATUS, 32'h0000_1808, "mstatus_wr");
        check("mstatus_mie_set", {31'd0, mstatus_mie}, 32'd1);
        trap = 1'b1; pc = 32'h0000_0123; mcause = 32'h8000_0003;
        tick();
        trap = 1'b0;
        check("trap_mepc", mepc, 32'h0000_0120);
        rd(A_MSTATUS, 32'h0000_1880, "trap_mstatus");
        rd(A_MCAUSE, 32'h8000_0003, "trap_mcause");
        mret = 1'b1;
        tick();
        mret = 1'b0;
        rd(A_MSTATUS, 32'h0000_1888, "mret_mstatus");
        check("mret_mie", {31'd0, mstatus_mie}, 32'd1);

        // Interrupt pending path
        wr(OP_RS, A_MIE, 32'h0000_0080);
        check("mie_rs", mie, 32'h0000_0080);
        irq = 32'h0000_0080; #1;
        check("irq_before_reg", {31'd0, irq_out}, 32'd0);
        tick();
        check("irq_pending", {31'd0, irq_out}, 32'd1);
        rd(A_MIP, 32'h0000_0080, "mip_read");
        wr(OP_RC, A_MSTATUS, 32'h0000_0008);
        check("irq_masked", {31'd0, irq_out}, 32'd0);
        rd(A_MSTATUS, 32'h0000_1880, "mstatus_rc");
        irq = 32'd0;

        // Priority: trap over mret over write
        wr(OP_RW, A_MSCRATCH, 32'hA5A5_0000);
        rd(A_MSCRATCH, 32'hA5A5_0000, "mscratch_wr");
        set_op(OP_RW, A_MSCRATCH, 32'h1234_5678);
        trap = 1'b1; mret = 1'b1; pc = 32'h0000_0200; mcause = 32'h0000_000B;
        tick();
        we = 1'b0; trap = 1'b0; mret = 1'b0;
        rd(A_MSCRATCH, 32'hA5A5_0000, "prio_mscratch");
        check("prio_mepc", mepc, 32'h0000_0200);
        rd(A_MSTATUS, 32'h0000_1800, "prio_mstatus");
        set_op(OP_RW, A_MSCRATCH, 32'h1234_5678);
        mret = 1'b1;
        tick();
        we = 1'b0; mret = 1'b0;
        rd(A_MSCRATCH, 32'hA5A5_0000, "mret_wr_mscratch");
        rd(A_MSTATUS, 32'h0000_1880, "mret_wr_mstatus");

        // Set/clear and masking
        wr(OP_RS, A_MSCRATCH, 32'h0000_00FF);
        rd(A_MSCRATCH, 32'hA5A5_00FF, "mscratch_rs");
        wr(OP_RCI, A_MSCRATCH, 32'h0000_000F);
        rd(A_MSCRATCH, 32'hA5A5_00F0, "mscratch_rci");
        wr(OP_RW, A_MEPC, 32'h0000_1237);
        check("mepc_mask", mepc, 32'h0000_1234);

        // Illegal accesses
        irq = 32'h0000_0004;
        tick();
        set_op(OP_RW, A_MIP, 32'hFFFF_FFFF); #1;
        check("ill_rw_mip", {31'd0, illegal}, 32'd1);
        tick();
        we = 1'b0;
        rd(A_MIP, 32'h0000_0004, "ill_mip_kept");
        set_op(OP_RW, 12'h7C0, 32'h1); #1;
        check("ill_addr", {31'd0, illegal}, 32'd1);
        set_op(OP_RW, A_MHARTID, 32'h1); #1;
        check("ill_rw_hartid", {31'd0, illegal}, 32'd1);
        set_op(OP_RS, A_MIP, 32'h0); #1;
        check("legal_rs_mip", {31'd0, illegal}, 32'd0);
        set_op(OP_RW, A_MCYCLE, 32'h0); #1;
        check("legal_mcycle", {31'd0, illegal}, 32'd0);
        set_op(OP_BAD, A_MSCRATCH, 32'h0000_0000); #1;
        check("ill_opcode", {31'd0, illegal}, 32'd1);
        tick();
        we = 1'b0;
        rd(A_MSCRATCH, 32'hA5A5_00F0, "ill_mscratch_kept");
        irq = 32'd0;

        // Counter carry
        wr(OP_RW, A_MCYCLE, 32'hFFFF_FFFE);
        wr(OP_RW, A_MCYCLEH, 32'h0000_0000);
        tick();
        rd(A_MCYCLE, 32'hFFFF_FFFF, "mcycle_ff");
        rd(A_MCYCLEH, 32'h0000_0000, "mcycleh_0");
        tick();
        rd(A_MCYCLE, 32'h0000_0000, "mcycle_wrap");
        rd(A_MCYCLEH, 32'h0000_0001, "mcycleh_carry");

        // minstret write beats a simultaneous retire
        rd(A_MINSTRETH, 32'd0, "minstreth_0");
        instret = 1'b1;
        wr(OP_RW, A_MINSTRET, 32'h0000_0100);
        instret = 1'b0;
        rd(A_MINSTRET, 32'h0000_0100, "minstret_wr");
        instret = 1'b1;
        tick();
        instret = 1'b0;
        rd(A_MINSTRET, 32'h0000_0101, "minstret_inc");
        wr(OP_RW, A_MINSTRET, 32'hFFFF_FFFF);
        instret = 1'b1;
        tick();
        instret = 1'b0;
        rd(A_MINSTRET, 32'h0000_0000, "minstret_wrap");
        rd(A_MINSTRETH, 32'h0000_0001, "minstreth_carry");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
